// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: MIPS decode/execute forwarding selects, load-use/branch stalls and divide sequencer
module hazard_fwd_unit #(
  parameter int DIV_CYCLES = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] rsD,
  input  logic [RA_W-1:0] rtD,
  input  logic            branchD,
  input  logic            jrD,
  input  logic [RA_W-1:0] rsE,
  input  logic [RA_W-1:0] rtE,
  input  logic [RA_W-1:0] writeregE,
  input  logic            regwriteE,
  input  logic            memtoregE,
  input  logic [RA_W-1:0] writeregM,
  input  logic            regwriteM,
  input  logic            memtoregM,
  input  logic [RA_W-1:0] writeregW,
  input  logic            regwriteW,
  input  logic            div_startE,
  output logic [1:0]      forwardaD,
  output logic [1:0]      forwardbD,
  output logic [1:0]      forwardaE,
  output logic [1:0]      forwardbE,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            flushE,
  output logic            flushM,
  output logic            div_go,
  output logic            div_busy,
  output logic            div_done
);
  localparam int CW = $clog2(DIV_CYCLES);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic lwstall, brstall, divstall, stall;
  function automatic logic hit(input logic we, input logic [RA_W-1:0] dst, input logic [RA_W-1:0] src);
    return we && dst != '0 && dst == src;
  endfunction
  always_comb begin
    forwardaD = hit(regwriteM, writeregM, rsD) ? 2'b01 : hit(regwriteW, writeregW, rsD) ? 2'b10 : 2'b00;
    forwardbD = hit(regwriteM, writeregM, rtD) ? 2'b01 : hit(regwriteW, writeregW, rtD) ? 2'b10 : 2'b00;
    forwardaE = hit(regwriteM, writeregM, rsE) ? 2'b10 : hit(regwriteW, writeregW, rsE) ? 2'b01 : 2'b00;
    forwardbE = hit(regwriteM, writeregM, rtE) ? 2'b10 : hit(regwriteW, writeregW, rtE) ? 2'b01 : 2'b00;
    lwstall = hit(memtoregE && regwriteE, writeregE, rsD) || hit(memtoregE && regwriteE, writeregE, rtD);
    brstall = (branchD || jrD) && (hit(regwriteE, writeregE, rsD) || hit(regwriteE, writeregE, rtD)
              || hit(memtoregM, writeregM, rsD) || hit(memtoregM, writeregM, rtD));
    div_go = state == IDLE && div_startE;
    divstall = div_go || state == BUSY;
    stall = lwstall || brstall || divstall;
    stallF = stall;
    stallD = stall;
    stallE = divstall;
    flushM = divstall;
    flushE = (lwstall || brstall) && !divstall;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      div_busy <= 1'b0;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (state == IDLE && div_startE) begin
        state <= BUSY;
        cnt <= CW'(DIV_CYCLES - 1);
        div_busy <= 1'b1;
      end else if (state == BUSY) begin
        cnt <= cnt - CW'(1);
        if (cnt == '0) begin
          state <= DONE;
          div_busy <= 1'b0;
          div_done <= 1'b1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed vectors, divide sequences and random stimulus against a reference model
module tb_hazard_fwd_unit;
  localparam int DC = 4;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic branchD, jrD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW, div_startE;
  logic [1:0] forwardaD, forwardbD, forwardaE, forwardbE;
  logic stallF, stallD, stallE, flushE, flushM, div_go, div_busy, div_done;
  int checks = 0;
  int failures = 0;
  int m_left = 0;
  bit m_done = 0;

  hazard_fwd_unit #(.DIV_CYCLES(DC), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwriteW(regwriteW), .div_startE(div_startE),
    .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE), .flushM(flushM),
    .div_go(div_go), .div_busy(div_busy), .div_done(div_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, w_e, w_m, w_w;
    logic br, jr, rw_e, mt_e, rw_m, mt_m, rw_w;
    logic [7:0] fwd;
    logic [1:0] st_fl;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs_d, rt_d, rs_e, rt_e, w_e, w_m, w_w,
                              input logic br, jr, rw_e, mt_e, rw_m, mt_m, rw_w,
                              input logic [7:0] fwd, input logic [1:0] st_fl);
    vec_t v;
    v.rs_d = rs_d; v.rt_d = rt_d; v.rs_e = rs_e; v.rt_e = rt_e;
    v.w_e = w_e; v.w_m = w_m; v.w_w = w_w;
    v.br = br; v.jr = jr; v.rw_e = rw_e; v.mt_e = mt_e; v.rw_m = rw_m; v.mt_m = mt_m; v.rw_w = rw_w;
    v.fwd = fwd; v.st_fl = st_fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {branchD, jrD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW, div_startE} = '0;
    rst = 1'b0;
  endtask

  // youngest producer wins; D and E muxes number their M/W inputs oppositely
  function automatic logic [1:0] efwd(input bit dstage, input logic [4:0] src);
    logic [4:0] dst [2];
    bit we [2];
    dst[0] = writeregM; we[0] = regwriteM;
    dst[1] = writeregW; we[1] = regwriteW;
    for (int i = 0; i < 2; i++)
      if (we[i] && dst[i] != 0 && dst[i] == src)
        return (i == 0) == dstage ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return r != 0 && (r == rsD || r == rtD);
  endfunction

  task automatic check_model(input string tag);
    bit busy, idle, ds, lw, br, s;
    busy = m_left > 0;
    idle = !busy && !m_done;
    ds = (idle && div_startE) || busy;
    lw = memtoregE && regwriteE && reads(writeregE);
    br = (branchD || jrD) && ((regwriteE && reads(writeregE)) || (memtoregM && reads(writeregM)));
    s = lw || br || ds;
    chk({tag, "_fwd"}, {24'd0, forwardaD, forwardbD, forwardaE, forwardbE},
        {24'd0, efwd(1, rsD), efwd(1, rtD), efwd(0, rsE), efwd(0, rtE)});
    chk({tag, "_ctl"}, {24'd0, stallF, stallD, stallE, flushE, flushM, div_go, div_busy, div_done},
        {24'd0, s, s, ds, (lw || br) && !ds, ds, idle && div_startE, busy, m_done});
  endtask

  task automatic tick();
    bit start_now, r;
    start_now = div_startE;
    r = rst;
    @(posedge clk);
    #1;
    if (r) begin m_left = 0; m_done = 0; end
    else if (m_done) m_done = 0;
    else if (m_left > 0) begin m_left--; if (m_left == 0) m_done = 1; end
    else if (start_now) m_left = DC;
  endtask

  vec_t vecs [11];
  int busy_cnt;
  bit seen_done;

  initial begin
    vecs[0]  = mk(8, 0, 8, 0, 0, 8, 8, 0, 0, 0, 0, 1, 0, 1, 8'b01_00_10_00, 2'b00);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 8'b00_00_00_00, 2'b00);
    vecs[2]  = mk(0, 3, 0, 3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 8'b00_10_00_01, 2'b00);
    vecs[3]  = mk(5, 0, 5, 0, 0, 5, 5, 0, 0, 0, 0, 0, 0, 1, 8'b10_00_01_00, 2'b00);
    vecs[4]  = mk(0, 9, 0, 0, 9, 0, 0, 0, 0, 1, 1, 0, 0, 0, 8'b00_00_00_00, 2'b11);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 8'b00_00_00_00, 2'b00);
    vecs[6]  = mk(4, 0, 0, 0, 4, 0, 0, 1, 0, 1, 0, 0, 0, 0, 8'b00_00_00_00, 2'b11);
    vecs[7]  = mk(4, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0, 1, 1, 0, 8'b01_00_00_00, 2'b11);
    vecs[8]  = mk(4, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0, 1, 0, 0, 8'b01_00_00_00, 2'b00);
    vecs[9]  = mk(0, 7, 0, 0, 7, 0, 0, 0, 1, 1, 0, 0, 0, 0, 8'b00_00_00_00, 2'b11);
    vecs[10] = mk(4, 0, 0, 0, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'b00_00_00_00, 2'b00);

    clear();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {30'd0, div_busy, div_done}, 32'd0);
    tick();

    foreach (vecs[i]) begin
      clear();
      rsD = vecs[i].rs_d; rtD = vecs[i].rt_d; rsE = vecs[i].rs_e; rtE = vecs[i].rt_e;
      writeregE = vecs[i].w_e; writeregM = vecs[i].w_m; writeregW = vecs[i].w_w;
      branchD = vecs[i].br; jrD = vecs[i].jr; regwriteE = vecs[i].rw_e; memtoregE = vecs[i].mt_e;
      regwriteM = vecs[i].rw_m; memtoregM = vecs[i].mt_m; regwriteW = vecs[i].rw_w;
      @(negedge clk);
      chk($sformatf("vec%0d_fwd", i), {24'd0, forwardaD, forwardbD, forwardaE, forwardbE}, {24'd0, vecs[i].fwd});
      chk($sformatf("vec%0d_ctl", i), {28'd0, stallF, stallD, stallE, flushE},
          {28'd0, vecs[i].st_fl[1], vecs[i].st_fl[1], 1'b0, vecs[i].st_fl[0]});
      tick();
    end

    clear();
    memtoregE = 1; regwriteE = 1; writeregE = 9; rtD = 9;
    @(negedge clk);
    chk("lw_stall", {28'd0, stallF, stallD, flushE, stallE}, 32'b1110);
    tick();
    memtoregE = 0;
    @(negedge clk);
    chk("lw_release", {28'd0, stallF, stallD, flushE, stallE}, 32'b0000);
    tick();

    clear();
    div_startE = 1;
    for (int c = 0; c <= DC + 1; c++) begin
      @(negedge clk);
      chk($sformatf("div_cyc%0d", c), {25'd0, stallF, stallE, flushE, flushM, div_go, div_busy, div_done},
          c == 0 ? 32'b1101100 : c <= DC ? 32'b1101010 : 32'b0000001);
      tick();
    end
    @(negedge clk);
    chk("div_b2b_restart", {30'd0, div_go, div_busy}, 32'b10);
    tick();
    div_startE = 0;
    for (int c = 0; c < DC + 1; c++) tick();
    @(negedge clk);
    check_model("div_b2b_end");
    tick();

    clear();
    div_startE = 1;
    tick();
    memtoregE = 1; regwriteE = 1; writeregE = 9; rtD = 9;
    @(negedge clk);
    chk("divlw_busy", {29'd0, stallF, stallE, flushE}, 32'b110);
    for (int c = 0; c < DC; c++) tick();
    @(negedge clk);
    chk("divlw_done", {28'd0, stallF, stallE, flushE, div_done}, 32'b1011);
    clear();
    tick();

    div_startE = 1;
    tick();
    tick();
    rst = 1;
    @(negedge clk);
    chk("rst_pre_busy", {31'd0, div_busy}, 32'd1);
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_abort", {29'd0, div_go, div_busy, div_done}, 32'b100);
    busy_cnt = 0;
    seen_done = 0;
    for (int c = 0; c < 4 * DC && !seen_done; c++) begin
      tick();
      @(negedge clk);
      if (div_busy) busy_cnt++;
      if (div_done) seen_done = 1;
    end
    chk("rst_restart_len", {31'd0, seen_done}, 32'd1);
    chk("rst_restart_busy", busy_cnt, DC);
    clear();
    tick();

    for (int n = 0; n < 3000; n++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      {branchD, jrD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW} = 7'($urandom);
      div_startE = $urandom_range(0, 2) != 0;
      rst = $urandom_range(0, 80) == 0;
      @(negedge clk);
      check_model("rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
